// File: rtl/monster_pkg.sv
// Shared types and constants for the monster spawn controller.
package monster_pkg;

  typedef enum logic [1:0] {IDLE, DRAW, CHECK, OFFER} spawn_state_t;

  localparam logic [31:0] SEED_DEFAULT = 32'h2545F491;
  localparam int XS_SHL_A = 13;
  localparam int XS_SHR_B = 17;
  localparam int XS_SHL_C = 5;

  function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << XS_SHL_A);
    t = t ^ (t >> XS_SHR_B);
    t = t ^ (t << XS_SHL_C);
    return t;
  endfunction

endpackage

// File: rtl/prng_xorshift32.sv
// 32-bit xorshift generator; a zero seed falls back to SEED_DEFAULT so the state never sticks at 0.
module prng_xorshift32
  import monster_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  always_ff @(posedge clk) begin
    if (reset || load) state <= (seed == 32'd0) ? SEED_DEFAULT : seed;
    else if (step)     state <= xorshift32_next(state);
  end

endmodule

// File: rtl/monster_spawn_ctrl.sv
// Periodic per-channel spawn requests, round-robin arbitration and random slot selection.
// Optional macro MONSTER_OCC_AVOID_EN: redraw when the drawn slot is occupied, drop after MAX_RETRY.
module monster_spawn_ctrl
  import monster_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int NUM_SLOTS = 21,
  parameter int TICK_DIV  = 50000000,
  parameter int PER_W     = 4,
  parameter int MAX_RETRY = 3,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IDX_W = $clog2(NUM_SLOTS)
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [31:0]             seed,
  input  logic [NUM_CH*PER_W-1:0] period,
  input  logic [NUM_SLOTS-1:0]    occupied,
  output logic                    spawn_valid,
  input  logic                    spawn_ready,
  output logic [CH_W-1:0]         spawn_ch,
  output logic [IDX_W-1:0]        spawn_idx,
  output logic [NUM_CH-1:0]       overrun,
  output logic [7:0]              drop_cnt
);

`ifdef MONSTER_OCC_AVOID_EN
  localparam bit OCC_EN = 1'b1;
`else
  localparam bit OCC_EN = 1'b0;
`endif

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  spawn_state_t        fsm;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick, ch_adv;
  logic [NUM_CH-1:0]   ch_req, pending, clr_vec;
  logic [CH_W-1:0]     sel_ch, rr_ptr, rr_sel, hi_sel, lo_sel;
  logic                rr_found, hi_found, lo_found;
  logic [RTY_W-1:0]    retry;
  logic [31:0]         prng_state;
  logic [IDX_W-1:0]    draw_idx;
  logic                slot_busy, retry_left, drop_now, accept;

  // Free-running base tick, independent of enable
  assign tick   = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign ch_adv = tick && enable;

  always_ff @(posedge clk) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // >= rather than == so a period shrunk below the count wraps on the next tick
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [PER_W-1:0] per, cnt;
    assign per       = period[g*PER_W +: PER_W];
    assign ch_req[g] = ch_adv && (per != '0) && (cnt >= per - 1'b1);
    always_ff @(posedge clk) begin
      if (reset)                      cnt <= '0;
      else if (ch_adv && per != '0)   cnt <= ch_req[g] ? '0 : cnt + 1'b1;
    end
  end

  // Round-robin: lowest pending channel above rr_ptr, else lowest at or below it
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pending[c]) begin
        if (CH_W'(c) > rr_ptr) begin hi_found = 1'b1; hi_sel = CH_W'(c); end
        else                   begin lo_found = 1'b1; lo_sel = CH_W'(c); end
      end
    end
    rr_found = hi_found || lo_found;
    rr_sel   = hi_found ? hi_sel : lo_sel;
  end

  prng_xorshift32 u_prng (
    .clk   (clk),
    .reset (reset),
    .load  (reset),
    .seed  (seed),
    .step  (fsm == DRAW),
    .state (prng_state)
  );

  assign draw_idx   = IDX_W'(prng_state % 32'(NUM_SLOTS));
  assign slot_busy  = OCC_EN && occupied[draw_idx];
  assign retry_left = (retry < RTY_W'(MAX_RETRY));
  assign drop_now   = (fsm == CHECK) && slot_busy && !retry_left;
  assign accept     = spawn_valid && spawn_ready;

  always_comb begin
    clr_vec = '0;
    if (accept || drop_now) clr_vec[sel_ch] = 1'b1;
  end

  // A request landing in the clear cycle re-arms pending without flagging overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      overrun <= overrun | (ch_req & pending & ~clr_vec);
      pending <= (pending & ~clr_vec) | ch_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm         <= IDLE;
      sel_ch      <= '0;
      rr_ptr      <= CH_W'(NUM_CH - 1);
      retry       <= '0;
      spawn_valid <= 1'b0;
      spawn_ch    <= '0;
      spawn_idx   <= '0;
      drop_cnt    <= '0;
    end else begin
      case (fsm)
        IDLE: if (rr_found) begin
          sel_ch <= rr_sel;
          rr_ptr <= rr_sel;
          retry  <= '0;
          fsm    <= DRAW;
        end
        DRAW: fsm <= CHECK;
        CHECK: begin
          if (!slot_busy) begin
            spawn_valid <= 1'b1;
            spawn_ch    <= sel_ch;
            spawn_idx   <= draw_idx;
            fsm         <= OFFER;
          end else if (retry_left) begin
            retry <= retry + 1'b1;
            fsm   <= DRAW;
          end else begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            fsm <= IDLE;
          end
        end
        OFFER: if (spawn_ready) begin
          spawn_valid <= 1'b0;
          fsm         <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
